// File: rtl/palette_pkg.sv
`default_nettype none
// ============================================================================
// Module  : palette_pkg
// Purpose : Shared definitions for the palette lookup block: effect-mode
//           encodings and the 8-entry default palette (4-bit nibbles per
//           channel, {ch2,ch1,ch0}).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package palette_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_FLASH  = 2'b01,
        MODE_DIM    = 2'b10,
        MODE_FADE   = 2'b11
    } mode_e;

    localparam int DEFAULT_ENTRIES = 8;

    // Default palette at 4 bits per channel; callers widen to CH_W.
    function automatic logic [11:0] default_entry(input int idx);
        logic [11:0] val;
        case (idx)
            0:       val = 12'h666;
            1:       val = 12'hFF0;
            2:       val = 12'h0FF;
            3:       val = 12'hC0C;
            4:       val = 12'h0F0;
            5:       val = 12'h00F;
            6:       val = 12'hF00;
            7:       val = 12'h07F;
            default: val = 12'h000;
        endcase
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_fx.sv
`default_nettype none
// ============================================================================
// Module  : palette_fx
// Purpose : Per-channel stage-2 effect (combinational).
//           NORMAL passes through, DIM halves, FADE subtracts fade level
//           saturating at 0, FLASH forces all-ones when flash_i is set.
// Ports   : ch_i    - channel value from the palette entry
//           mode_i  - effect mode captured with the pixel
//           fade_i  - fade level captured with the pixel
//           flash_i - blink phase AND per-type flash enable
//           ch_o    - processed channel value
// Rev     : 1.0  initial release
// ============================================================================
module palette_fx
    import palette_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0] ch_i,
    input  mode_e           mode_i,
    input  logic [CH_W-1:0] fade_i,
    input  logic            flash_i,
    output logic [CH_W-1:0] ch_o
);

    always_comb begin
        ch_o = ch_i;
        case (mode_i)
            MODE_NORMAL: ch_o = ch_i;
            MODE_FLASH:  ch_o = flash_i ? '1 : ch_i;
            MODE_DIM:    ch_o = ch_i >> 1;
            MODE_FADE:   ch_o = (ch_i > fade_i) ? (ch_i - fade_i) : '0;
            default:     ch_o = ch_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/palette_lut.sv
`default_nettype none
// ============================================================================
// Module  : palette_lut
// Purpose : Block-type to colour lookup with writable palette and frame-based
//           effects. Two-stage pipeline: stage 1 reads the palette entry and
//           captures the effect controls, stage 2 applies the effect.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           type_i, pix_valid_i - pixel block-type code and its qualifier
//           color_o, color_valid_o - {ch2,ch1,ch0} result, 2 cycles later
//           wr_en_i, wr_addr_i, wr_data_i - palette write port
//           mode_i            - 00 NORMAL, 01 FLASH, 10 DIM, 11 FADE
//           flash_mask_i      - per-type flash enable
//           frame_tick_i      - one-cycle pulse per video frame
// Rev     : 1.0  initial release
// ============================================================================
module palette_lut
    import palette_pkg::*;
#(
    parameter int TYPE_W    = 3,
    parameter int CH_W      = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TYPE_W-1:0]    type_i,
    input  logic                 pix_valid_i,
    output logic [3*CH_W-1:0]    color_o,
    output logic                 color_valid_o,
    input  logic                 wr_en_i,
    input  logic [TYPE_W-1:0]    wr_addr_i,
    input  logic [3*CH_W-1:0]    wr_data_i,
    input  logic [1:0]           mode_i,
    input  logic [2**TYPE_W-1:0] flash_mask_i,
    input  logic                 frame_tick_i
);

    localparam int DEPTH = 2**TYPE_W;
    localparam int PIX_W = 3*CH_W;
    localparam int REP   = (CH_W + 3) / 4;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [CH_W-1:0]  FADE_MAX   = '1;

    // Left-align the nibble and fill the low bits by repeating it from the
    // MSB down, so full-scale F maps to all-ones at any CH_W.
    function automatic logic [CH_W-1:0] widen_nib(input logic [3:0] nib);
        logic [4*REP-1:0] rep;
        rep = {REP{nib}};
        return rep[4*REP-1 -: CH_W];
    endfunction

    function automatic logic [PIX_W-1:0] widen_entry(input logic [11:0] ent);
        return {widen_nib(ent[11:8]), widen_nib(ent[7:4]), widen_nib(ent[3:0])};
    endfunction

    mode_e mode_w;
    assign mode_w = mode_e'(mode_i);

    // ------------------------------------------------------------------
    // Palette: one reset register per entry. Stage 1 samples the entry
    // value from before the edge, giving read-before-write on collision.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] entry_w [DEPTH];

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam logic [PIX_W-1:0]  RST_VAL =
            (e < DEFAULT_ENTRIES) ? widen_entry(default_entry(e)) : '0;
        localparam logic [TYPE_W-1:0] ADDR = TYPE_W'(e);

        logic [PIX_W-1:0] entry_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_q <= RST_VAL;
            end else if (wr_en_i && (wr_addr_i == ADDR)) begin
                entry_q <= wr_data_i;
            end
        end

        assign entry_w[e] = entry_q;
    end

    // ------------------------------------------------------------------
    // Frame-rate effect state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [CH_W-1:0]  fade_lvl_q, fade_lvl_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick_i) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        fade_lvl_d = fade_lvl_q;
        if (mode_w != MODE_FADE) begin
            fade_lvl_d = '0;
        end else if (frame_tick_i && (fade_lvl_q != FADE_MAX)) begin
            fade_lvl_d = fade_lvl_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers. Stage 1 captures the effect controls with the
    // entry so a pixel never sees a mix of old and new settings.
    // ------------------------------------------------------------------
    logic             s1_valid_q;
    logic [PIX_W-1:0] s1_entry_q;
    mode_e            s1_mode_q;
    logic             s1_flash_q;
    logic [CH_W-1:0]  s1_fade_q;
    logic [PIX_W-1:0] color_q, color_d;
    logic             color_valid_q;
    logic [PIX_W-1:0] fx_color_w;

    for (genvar c = 0; c < 3; c++) begin : g_fx
        palette_fx #(
            .CH_W (CH_W)
        ) u_fx (
            .ch_i    (s1_entry_q[c*CH_W +: CH_W]),
            .mode_i  (s1_mode_q),
            .fade_i  (s1_fade_q),
            .flash_i (s1_flash_q),
            .ch_o    (fx_color_w[c*CH_W +: CH_W])
        );
    end

    assign color_d = s1_valid_q ? fx_color_w : color_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            fade_lvl_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_entry_q    <= '0;
            s1_mode_q     <= MODE_NORMAL;
            s1_flash_q    <= 1'b0;
            s1_fade_q     <= '0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            fade_lvl_q    <= fade_lvl_d;
            s1_valid_q    <= pix_valid_i;
            s1_entry_q    <= entry_w[type_i];
            s1_mode_q     <= mode_w;
            s1_flash_q    <= blink_phase_q & flash_mask_i[type_i];
            s1_fade_q     <= fade_lvl_q;
            color_q       <= color_d;
            color_valid_q <= s1_valid_q;
        end
    end

    assign color_o       = color_q;
    assign color_valid_o = color_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_palette_lut.sv
`default_nettype none
// ============================================================================
// Module  : tb_palette_lut
// Purpose : Self-checking bench for palette_lut (TYPE_W=3, CH_W=4,
//           BLINK_DIV=2): vector table, directed corner sequences and a
//           randomized run against a frame-counting reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_palette_lut;

    localparam int BLINK_DIV = 2;
    localparam int N_RAND    = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  type_i = '0;
    logic        pix_valid_i = 1'b0;
    logic [11:0] color_o;
    logic        color_valid_o;
    logic        wr_en_i = 1'b0;
    logic [2:0]  wr_addr_i = '0;
    logic [11:0] wr_data_i = '0;
    logic [1:0]  mode_i = 2'b00;
    logic [7:0]  flash_mask_i = '0;
    logic        frame_tick_i = 1'b0;

    palette_lut #(
        .TYPE_W    (3),
        .CH_W      (4),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .type_i        (type_i),
        .pix_valid_i   (pix_valid_i),
        .color_o       (color_o),
        .color_valid_o (color_valid_o),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .mode_i        (mode_i),
        .flash_mask_i  (flash_mask_i),
        .frame_tick_i  (frame_tick_i)
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int n_checks = 0;

    // ---------------- reference model ----------------
    logic [11:0] m_pal [8];
    int          ticks;       // frame ticks since reset (any mode)
    int          fade_ticks;  // frame ticks since FADE was entered
    logic        e1_v;
    logic [11:0] e1_c;
    logic        mv_out;
    logic [11:0] mc_out;

    function automatic logic [11:0] ref_color(input logic [11:0] ent, input int md,
                                              input bit fl, input int fd);
        logic [11:0] r;
        int ch;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            ch = int'(ent[4*k +: 4]);
            case (md)
                1:       if (fl) ch = 15;
                2:       ch = ch / 2;
                3:       ch = (ch > fd) ? ch - fd : 0;
                default: ;
            endcase
            r[4*k +: 4] = 4'(ch);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_pal[0] = 12'h666; m_pal[1] = 12'hFF0; m_pal[2] = 12'h0FF; m_pal[3] = 12'hC0C;
        m_pal[4] = 12'h0F0; m_pal[5] = 12'h00F; m_pal[6] = 12'hF00; m_pal[7] = 12'h07F;
        ticks = 0; fade_ticks = 0;
        e1_v = 1'b0; e1_c = '0; mv_out = 1'b0; mc_out = '0;
    endtask

    // Advance model with the inputs presented this cycle, then clock the DUT.
    task automatic cycle();
        bit phase;
        int fd;
        phase = ((ticks / BLINK_DIV) % 2) == 1;
        fd    = (fade_ticks > 15) ? 15 : fade_ticks;
        if (e1_v) mc_out = e1_c;
        mv_out = e1_v;
        e1_v   = pix_valid_i;
        if (pix_valid_i)
            e1_c = ref_color(m_pal[type_i], int'(mode_i), phase && flash_mask_i[type_i], fd);
        if (wr_en_i) m_pal[wr_addr_i] = wr_data_i;
        if (frame_tick_i) ticks++;
        if (mode_i != 2'b11) fade_ticks = 0;
        else if (frame_tick_i) fade_ticks++;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%0d color=%03h, expected valid=%0d color=%03h",
                     name, got[12], got[11:0], exp[12], exp[11:0]);
        end
    endtask

    task automatic do_reset();
        pix_valid_i = 0; wr_en_i = 0; frame_tick_i = 0; mode_i = 2'b00; flash_mask_i = '0;
        rst = 1'b1;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ticks_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick_i = 1'b1;
            cycle();
            frame_tick_i = 1'b0;
            cycle();
        end
    endtask

    // Present one pixel, idle one cycle; result is visible afterwards.
    task automatic lookup(input logic [2:0] t, input logic [1:0] m);
        type_i = t; mode_i = m; pix_valid_i = 1'b1;
        cycle();
        pix_valid_i = 1'b0;
        cycle();
    endtask

    typedef struct packed {
        logic [2:0]  t;
        logic [1:0]  m;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{3'd3, 2'b00, 12'hC0C};
        vecs[1]  = '{3'd0, 2'b00, 12'h666};
        vecs[2]  = '{3'd1, 2'b00, 12'hFF0};
        vecs[3]  = '{3'd2, 2'b00, 12'h0FF};
        vecs[4]  = '{3'd4, 2'b00, 12'h0F0};
        vecs[5]  = '{3'd5, 2'b00, 12'h00F};
        vecs[6]  = '{3'd6, 2'b00, 12'hF00};
        vecs[7]  = '{3'd7, 2'b00, 12'h07F};
        vecs[8]  = '{3'd1, 2'b10, 12'h770};
        vecs[9]  = '{3'd0, 2'b10, 12'h333};
        vecs[10] = '{3'd2, 2'b10, 12'h077};
        vecs[11] = '{3'd3, 2'b10, 12'h606};
        vecs[12] = '{3'd4, 2'b10, 12'h070};
        vecs[13] = '{3'd5, 2'b10, 12'h007};
        vecs[14] = '{3'd6, 2'b10, 12'h700};
        vecs[15] = '{3'd7, 2'b10, 12'h037};

        model_reset();
        do_reset();
        check("reset_state", {color_valid_o, color_o}, {1'b0, 12'h000});

        // Default palette in NORMAL and DIM
        for (int i = 0; i < 16; i++) begin
            lookup(vecs[i].t, vecs[i].m);
            check($sformatf("vec%0d_type%0d_mode%0d", i, vecs[i].t, vecs[i].m),
                  {color_valid_o, color_o}, {1'b1, vecs[i].exp});
        end
        cycle();
        check("valid_drops_color_holds", {color_valid_o, color_o}, {1'b0, 12'h037});

        // Read-before-write collision on entry 2
        mode_i = 2'b00; type_i = 3'd2; pix_valid_i = 1'b1;
        wr_en_i = 1'b1; wr_addr_i = 3'd2; wr_data_i = 12'h123;
        cycle();
        wr_en_i = 1'b0;
        cycle();
        pix_valid_i = 1'b0;
        check("collision_old_value", {color_valid_o, color_o}, {1'b1, 12'h0FF});
        cycle();
        check("collision_new_value", {color_valid_o, color_o}, {1'b1, 12'h123});

        // FADE: 5 ticks, then saturate, then back to NORMAL
        mode_i = 2'b11;
        ticks_n(5);
        lookup(3'd4, 2'b11);
        check("fade_5", {color_valid_o, color_o}, {1'b1, 12'h0A0});
        ticks_n(15);
        lookup(3'd4, 2'b11);
        check("fade_sat", {color_valid_o, color_o}, {1'b1, 12'h000});
        lookup(3'd4, 2'b00);
        check("fade_to_normal", {color_valid_o, color_o}, {1'b1, 12'h0F0});

        // FLASH with BLINK_DIV=2, mask selects type 1 only
        do_reset();
        mode_i = 2'b01; flash_mask_i = 8'h02;
        ticks_n(2);
        type_i = 3'd1; pix_valid_i = 1'b1;
        cycle();
        type_i = 3'd6;
        cycle();
        pix_valid_i = 1'b0;
        check("flash_on_type1", {color_valid_o, color_o}, {1'b1, 12'hFFF});
        cycle();
        check("flash_unmasked_type6", {color_valid_o, color_o}, {1'b1, 12'hF00});
        ticks_n(2);
        lookup(3'd1, 2'b01);
        check("flash_off_type1", {color_valid_o, color_o}, {1'b1, 12'hFF0});

        // Reset with pixels in flight
        mode_i = 2'b00; flash_mask_i = '0;
        wr_en_i = 1'b1; wr_addr_i = 3'd2; wr_data_i = 12'h5A5;
        cycle();
        wr_en_i = 1'b0;
        type_i = 3'd3; pix_valid_i = 1'b1;
        cycle();
        type_i = 3'd2;
        cycle();
        check("inflight_before_rst", {color_valid_o, color_o}, {1'b1, 12'hC0C});
        #2;
        rst = 1'b1;
        pix_valid_i = 1'b0;
        #1;
        check("async_rst_clears", {color_valid_o, color_o}, {1'b0, 12'h000});
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("no_stale_%0d", i), {color_valid_o, color_o}, {1'b0, 12'h000});
        end
        lookup(3'd2, 2'b00);
        check("entry2_restored", {color_valid_o, color_o}, {1'b1, 12'h0FF});

        // Randomized run against the model
        for (int i = 0; i < N_RAND; i++) begin
            type_i       = 3'($urandom_range(0, 7));
            pix_valid_i  = ($urandom_range(0, 3) != 0);
            wr_en_i      = ($urandom_range(0, 7) == 0);
            wr_addr_i    = 3'($urandom_range(0, 7));
            wr_data_i    = 12'($urandom);
            frame_tick_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) flash_mask_i = 8'($urandom);
            cycle();
            check($sformatf("rand_%0d", i), {color_valid_o, color_o}, {mv_out, mc_out});
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL have parameter TYPE_W, default 3, meaning block-type code width; the palette holds 2**TYPE_W entries.
REQ-002 SHALL have parameter CH_W, default 4, meaning bits per colour channel; legal values are CH_W >= 4.
REQ-003 SHALL have parameter BLINK_DIV, default 16, meaning frame_tick count per blink half-period; legal values are BLINK_DIV >= 1.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide port type, input, TYPE_W bits: block-type code of the current pixel.
REQ-007 SHALL provide port pix_valid, input, 1 bit: qualifies type.
REQ-008 SHALL provide port color, output, 3*CH_W bits: {ch2,ch1,ch0}, registered.
REQ-009 SHALL provide port color_valid, output, 1 bit: qualifies color.
REQ-010 SHALL provide port wr_en, input, 1 bit: palette write strobe.
REQ-011 SHALL provide port wr_addr, input, TYPE_W bits: palette entry to write.
REQ-012 SHALL provide port wr_data, input, 3*CH_W bits: new entry value.
REQ-013 SHALL provide port mode, input, 2 bits: effect select; 00 NORMAL, 01 FLASH, 10 DIM, 11 FADE.
REQ-014 SHALL provide port flash_mask, input, 2**TYPE_W bits: per-type flash enable.
REQ-015 SHALL provide port frame_tick, input, 1 bit: one-cycle pulse per video frame.

Function
REQ-016 SHALL use a two-stage pipeline: stage 1 reads the palette entry, stage 2 applies the effect; color and color_valid appear exactly 2 cycles after the pix_valid/type sample.
REQ-017 SHALL pipeline pix_valid through to color_valid; when color_valid=0, color SHALL hold its previous value.
REQ-018 SHALL, on wr_en, write wr_data to entry wr_addr at the clock edge.
REQ-019 SHALL resolve a read and a write to the same entry in the same cycle as read-before-write: the lookup returns the old value.
REQ-020 SHALL, in NORMAL mode, output the palette entry unchanged.
REQ-021 SHALL, in DIM mode, shift each channel right by 1 bit.
REQ-022 SHALL keep blink_cnt, which counts frame_tick pulses from 0 to BLINK_DIV-1, then wraps to 0 and toggles blink_phase; this counter runs in all modes.
REQ-023 SHALL, in FLASH mode, output all-ones on all channels when blink_phase=1 and flash_mask[type]=1; otherwise it outputs the entry unchanged.
REQ-024 SHALL keep fade_lvl, CH_W bits, which increments on frame_tick only while mode=FADE and saturates at 2**CH_W-1.
REQ-025 SHALL clear fade_lvl to 0 on the first cycle mode != FADE.
REQ-026 SHALL, in FADE mode, output each channel as max(ch - fade_lvl, 0), i.e. subtraction saturating at 0.
REQ-027 SHALL take the mode, flash_mask, blink_phase and fade_lvl values used by stage 2 as registered alongside stage 1, so that each pixel is processed with a consistent effect.
REQ-028 SHALL apply a mode change to pixels sampled on or after the cycle the change is presented.
REQ-029 SHALL advance fade_lvl or blink_cnt only once when frame_tick coincides with a write or a mode change; all such events take effect independently.

Reset
REQ-030 SHALL, on rst assertion, clear color, color_valid, both pipeline valids, blink_cnt, blink_phase and fade_lvl to 0 immediately and asynchronously.
REQ-031 SHALL, on reset, load palette entries 0..7 with 4-bit defaults {ch2,ch1,ch0}: 0:666, 1:FF0, 2:0FF, 3:C0C, 4:0F0, 5:00F, 6:F00, 7:07F.
REQ-032 SHALL widen each default nibble to CH_W by left-aligning it and replicating its MSBs into the low bits.
REQ-033 SHALL reset entries 8 and above to 0.
REQ-034 SHALL discard any in-flight pixel when reset is asserted mid-stream; no color_valid is produced for it.
REQ-035 SHALL ignore a write that coincides with reset.

Structure
REQ-036 SHALL place the mode encodings and the 8-entry default palette table in a shared package, palette_pkg.
REQ-037 SHALL implement the palette as a register array with reset, not inferred block RAM.
REQ-038 SHALL implement the stage-2 per-channel effect (DIM, FADE and FLASH override) as sub-module palette_fx, instantiated 3 times.

Verification
REQ-039 SHALL cover reset then pix_valid=1, type=3 in NORMAL mode -> 2 cycles later color=C0C, color_valid=1.
REQ-040 SHALL cover writing wr_addr=2, wr_data=123 while type=2 is looked up in the same cycle -> first result 0FF; a repeat lookup gives 123.
REQ-041 SHALL cover DIM mode, type=1 -> color=770.
REQ-042 SHALL cover FADE mode with 5 frame_ticks then type=4 -> color=0A0; after 20 ticks -> 000; switching to NORMAL gives 0F0 on the next pixel.
REQ-043 SHALL cover FLASH mode, BLINK_DIV=2, flash_mask=8'h02: after 2 ticks, type=1 -> FFF and type=6 -> F00; after 2 more ticks, type=1 -> FF0.
REQ-044 SHALL cover rst asserted with 2 pixels in flight -> color=000 and color_valid=0 immediately, no stale output after release, and entry 2 restored to 0FF.
